shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/shift_step.sv | 21 ++
 rtl/shift_sequencer.sv | 129 ++++++++++++
 tb/tb_shift_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state encoding, default widths and step sizes for shift_sequencer
package shift_seq_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 6;
  localparam int STEP_BIG   = 8;
  localparam int STEP_SMALL = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT8 = 2'd1,
    SHIFT1 = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational right-shift step of 8 or 1 bits with a selectable fill bit
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] value,
  input  logic              sel8,
  input  logic              fill,
  output logic [DATA_W-1:0] shifted
);

  always_comb begin
    if (sel8) begin
      shifted = {{STEP_BIG{fill}}, value[DATA_W-1:STEP_BIG]};
    end else begin
      shifted = {{STEP_SMALL{fill}}, value[DATA_W-1:STEP_SMALL]};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle right shifter stepping by 8 then by 1 until the count is spent
// SHIFT_SEQ_ARITH_EN adds the arith port and sign-filled shifts.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [CNT_W-1:0]  shamt,
`ifdef SHIFT_SEQ_ARITH_EN
  input  logic              arith,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_work;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_result;
  logic                w_accept;
  logic                w_sel8;
  logic                w_fill;
  logic [DATA_W-1:0]   w_step_out;
  logic [CNT_W-1:0]    w_cnt_step;
  logic [CNT_W-1:0]    w_route_cnt;

`ifdef SHIFT_SEQ_ARITH_EN
  logic r_fill;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fill <= 1'b0;
    end else if (w_accept) begin
      r_fill <= arith & a[DATA_W-1];
    end
  end

  assign w_fill = r_fill;
`else
  assign w_fill = 1'b0;
`endif

  assign w_sel8     = (r_state == SHIFT8);
  assign w_cnt_step = r_cnt - (w_sel8 ? CNT_W'(STEP_BIG) : CNT_W'(STEP_SMALL));

  shift_step #(.DATA_W(DATA_W)) u_step (
    .value   (r_work),
    .sel8    (w_sel8),
    .fill    (w_fill),
    .shifted (w_step_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accept and shift steps share one routing rule on the count that remains afterwards.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_route_cnt = w_cnt_step;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (start && !abort) begin
          w_accept    = 1'b1;
          w_route_cnt = shamt;
        end
      end
      default: ;
    endcase
    if (r_state != IDLE || w_accept) begin
      if (w_state_nxt != IDLE || w_accept || r_state == SHIFT8 || r_state == SHIFT1) begin
        if (w_route_cnt >= CNT_W'(STEP_BIG)) begin
          w_state_nxt = SHIFT8;
        end else if (w_route_cnt != '0) begin
          w_state_nxt = SHIFT1;
        end else begin
          w_state_nxt = DONE;
        end
      end
    end
    if (r_state == DONE && !w_accept) begin
      w_state_nxt = IDLE;
    end
    if (abort) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_work <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_work <= a;
      r_cnt  <= shamt;
    end else if (!abort && (r_state == SHIFT8 || r_state == SHIFT1)) begin
      r_work <= w_step_out;
      r_cnt  <= w_cnt_step;
    end
  end

  // Result is written only on the edge that enters DONE, so it never shows a partial shift.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
    end else if (w_state_nxt == DONE) begin
      r_result <= w_accept ? a : w_step_out;
    end
  end

  assign busy   = (r_state == SHIFT8) || (r_state == SHIFT1);
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [63:0] a;
  logic [5:0]  shamt;
`ifdef SHIFT_SEQ_ARITH_EN
  logic        arith;
`endif
  logic        busy;
  logic        done;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen;

  always #5 clock = ~clock;

  shift_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .a       (a),
    .shamt   (shamt),
`ifdef SHIFT_SEQ_ARITH_EN
    .arith   (arith),
`endif
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    a       = '0;
    shamt   = '0;
`ifdef SHIFT_SEQ_ARITH_EN
    arith   = 1'b0;
`endif
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // shamt=0: accepted on the first edge after reset release, done right after
    a = 64'hF000_0000_0000_0000; shamt = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("s0_done", {63'd0, done}, 64'd1);
    chk("s0_busy", {63'd0, busy}, 64'd0);
    chk("s0_result", result, 64'hF000_0000_0000_0000);
    tick();
    chk("s0_idle_done", {63'd0, done}, 64'd0);
    chk("s0_hold", result, 64'hF000_0000_0000_0000);

    // shamt=17: two SHIFT8 then one SHIFT1
    a = 64'h8000_0000_0000_0001; shamt = 6'd17; start = 1'b1;
    tick();
    start = 1'b0;
    chk("s17_e1_busy", {63'd0, busy}, 64'd1);
    chk("s17_e1_done", {63'd0, done}, 64'd0);
    tick();
    chk("s17_e2_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("s17_e3_busy", {63'd0, busy}, 64'd1);
    chk("s17_no_partial", result, 64'hF000_0000_0000_0000);
    tick();
    chk("s17_e4_done", {63'd0, done}, 64'd1);
    chk("s17_e4_busy", {63'd0, busy}, 64'd0);
    chk("s17_result", result, 64'h0000_4000_0000_0000);
    tick();
    chk("s17_pulse", {63'd0, done}, 64'd0);

    // shamt=63: done after edge 15
    a = 64'hFFFF_FFFF_FFFF_FFFF; shamt = 6'd63; start = 1'b1;
`ifdef SHIFT_SEQ_ARITH_EN
    arith = 1'b1;
`endif
    tick();
    start = 1'b0;
    done_seen = 0;
    for (int i = 2; i <= 14; i++) begin
      tick();
      if (done) done_seen++;
    end
    chk("s63_early_done", 64'(done_seen), 64'd0);
    chk("s63_e14_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("s63_e15_done", {63'd0, done}, 64'd1);
`ifdef SHIFT_SEQ_ARITH_EN
    chk("s63_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    arith = 1'b1;
    a = 64'h8000_0000_0000_0001; shamt = 6'd17; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("ar17_done", {63'd0, done}, 64'd1);
    chk("ar17_result", result, 64'hFFFF_C000_0000_0000);
    arith = 1'b0;
`else
    chk("s63_result", result, 64'h0000_0000_0000_0001);
`endif
    tick();

    // start during SHIFT8 ignored, start during DONE accepted back-to-back
    a = 64'h0123_4567_89AB_CDEF; shamt = 6'd8; start = 1'b1;
    tick();
    a = 64'hFFFF_0000_0000_0000; shamt = 6'd4;
    tick();
    chk("b2b_first_done", {63'd0, done}, 64'd1);
    chk("b2b_first_result", result, 64'h0001_2345_6789_ABCD);
    tick();
    start = 1'b0;
    chk("b2b_second_busy", {63'd0, busy}, 64'd1);
    chk("b2b_second_nodone", {63'd0, done}, 64'd0);
    tick(); tick(); tick();
    chk("b2b_e6_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("b2b_second_done", {63'd0, done}, 64'd1);
    chk("b2b_second_result", result, 64'h0FFF_F000_0000_0000);
    tick();

    // abort in SHIFT1 with start high: back to IDLE, result untouched
    a = 64'hFFFF_FFFF_FFFF_FFFF; shamt = 6'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1; start = 1'b1; a = 64'h1234_0000_0000_0000; shamt = 6'd0;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", result, 64'h0FFF_F000_0000_0000);
    tick();
    chk("abort_idle_done", {63'd0, done}, 64'd0);

    // reset pulse mid-SHIFT8
    a = 64'hAAAA_AAAA_AAAA_AAAA; shamt = 6'd40; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_result", result, 64'd0);
    tick();
    reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    chk("post_rst_quiet", 64'(done_seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
